fpu_shared_rr: RTL and testbench

//  Multi-port FP execution unit shared by NUM_PORTS cores; successor to the single-requester DPI FPU.
//  Per-port decoupled req/resp handshakes with a round-robin issue arbiter, one issue per cycle.

---
 rtl/fpu_shared_rr.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fpu_shared_rr.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_shared_rr.sv
// Shared FP execution unit: NUM_PORTS req/resp ports, round-robin issue, concurrent per-port countdowns.
// Define FPU_SHARED_STATS_EN to add saturating stat_issued/stat_conflict/stat_busy counters.
module fpu_shared_rr #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_LAT   = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_PORTS-1:0]   req_valid,
  output logic [NUM_PORTS-1:0]   req_ready,
  input  logic [NUM_PORTS*32-1:0] req_a,
  input  logic [NUM_PORTS*32-1:0] req_b,
  input  logic [NUM_PORTS*7-1:0]  req_funct7,
  input  logic [NUM_PORTS*3-1:0]  req_funct3,
  input  logic [NUM_PORTS-1:0]   req_rs2b0,
  output logic [NUM_PORTS-1:0]   resp_valid,
  input  logic [NUM_PORTS-1:0]   resp_ready,
  output logic [NUM_PORTS*32-1:0] resp_data
`ifdef FPU_SHARED_STATS_EN
  ,
  output logic [31:0]            stat_issued,
  output logic [31:0]            stat_conflict,
  output logic [31:0]            stat_busy
`endif
);

  localparam int CW = $clog2(MAX_LAT + 1);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Synthesizable stand-in for the softfpu model: truncating single precision, normals only.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  ex, ey, er, sh;
    logic [24:0] mx, my, s;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex = x[30:23];
    ey = y[30:23];
    sh = ex - ey;
    mx = {2'b01, x[22:0]};
    my = {2'b01, y[22:0]};
    my = (sh > 8'd24) ? 25'd0 : (my >> sh);
    if (x[31] == y[31]) begin
      s = mx + my;
      if (s[24]) return {x[31], ex + 8'd1, s[23:1]};
      return {x[31], ex, s[22:0]};
    end
    s = mx - my;
    if (s == 25'd0) return 32'd0;
    er = ex;
    for (int i = 0; i < 24; i++) begin
      if (!s[23]) begin
        s  = s << 1;
        er = er - 8'd1;
      end
    end
    return {x[31], er, s[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [47:0] p;
    logic [9:0]  e;
    sgn = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sgn, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) return {sgn, 8'(e + 10'd1), p[46:24]};
    return {sgn, e[7:0], p[45:23]};
  endfunction

  function automatic logic [31:0] fp_sgnj(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3);
    logic [31:0] r;
    case (f3)
      3'd0:    r = {b[31], a[30:0]};
      3'd1:    r = {~b[31], a[30:0]};
      3'd2:    r = {a[31] ^ b[31], a[30:0]};
      default: r = a;
    endcase
    return r;
  endfunction

  // Integer to float; rs2 bit0 selects unsigned source.
  function automatic logic [31:0] fp_cvt(input logic [31:0] a, input logic uns);
    logic        neg;
    logic [31:0] mag, sh;
    int          p;
    neg = !uns && a[31];
    mag = neg ? -a : a;
    if (mag == 32'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    sh = mag << (31 - p);
    return {neg, 8'(127 + p), sh[30:8]};
  endfunction

  function automatic logic [31:0] softfpu_compute(input logic [31:0] a, input logic [31:0] b,
                                                  input logic [6:0] f7, input logic [2:0] f3,
                                                  input logic rs2b0);
    logic [31:0] r;
    case (f7)
      7'h00:   r = fp_add(a, b);
      7'h04:   r = fp_add(a, {~b[31], b[30:0]});
      7'h08:   r = fp_mul(a, b);
      7'h10:   r = fp_sgnj(a, b, f3);
      7'h68:   r = fp_cvt(a, rs2b0);
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic int softfpu_delay(input logic [6:0] f7, input logic [2:0] f3);
    int d;
    case (f7)
      7'h00, 7'h04: d = 3;
      7'h08:        d = 5;
      7'h10:        d = (f3 == 3'd0) ? 0 : -1;
      7'h68:        d = 100;
      default:      d = 2;
    endcase
    return d;
  endfunction

  logic [1:0]     state_q [NUM_PORTS];
  logic [CW-1:0]  cnt_q   [NUM_PORTS];
  logic [31:0]    data_q  [NUM_PORTS];
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_PORTS-1:0] idle, eligible, grant_oh;
  logic                 grant_any;
  logic [PW-1:0]        grant_idx;
  logic [31:0]          issue_res;
  logic [CW-1:0]        issue_lat;

  always_comb begin
    idle       = '0;
    resp_valid = '0;
    resp_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idle[i]             = (state_q[i] == S_IDLE);
      resp_valid[i]       = (state_q[i] == S_DONE);
      resp_data[32*i +: 32] = data_q[i];
    end
  end

  // Masking with idle also drops any X on req_valid of a BUSY/DONE port.
  assign eligible = req_valid & idle;

  always_comb begin
    int            t;
    logic [PW-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    t         = 0;
    idx       = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      t = int'(rr_ptr_q) + off;
      if (t >= NUM_PORTS) t = t - NUM_PORTS;
      idx = PW'(t);
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NUM_PORTS; i++) grant_oh[i] = grant_any && (grant_idx == PW'(i));
  end

  assign req_ready = grant_oh & {NUM_PORTS{reset_n}};

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
  end

  // Only the granted port's operands reach the model, so at most one evaluation per cycle.
  always_comb begin
    int raw_lat;
    issue_res = '0;
    issue_lat = CW'(1);
    raw_lat   = 1;
    if (grant_any) begin
      issue_res = softfpu_compute(req_a[32*grant_idx +: 32], req_b[32*grant_idx +: 32],
                                  req_funct7[7*grant_idx +: 7], req_funct3[3*grant_idx +: 3],
                                  req_rs2b0[grant_idx]);
      raw_lat   = softfpu_delay(req_funct7[7*grant_idx +: 7], req_funct3[3*grant_idx +: 3]);
      if (raw_lat < 1)            issue_lat = CW'(1);
      else if (raw_lat > MAX_LAT) issue_lat = CW'(MAX_LAT);
      else                        issue_lat = CW'(raw_lat);
    end
  end

  // NOTE: these per-port arrays are plain flops, not RAM; reset must clear them so an
  // aborted op cannot surface later, hence the loop in the reset branch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        case (state_q[i])
          S_IDLE: if (grant_oh[i]) begin
            state_q[i] <= S_BUSY;
            cnt_q[i]   <= issue_lat;
            data_q[i]  <= issue_res;
          end
          S_BUSY: if (cnt_q[i] == CW'(1)) begin
            state_q[i] <= S_DONE;
            cnt_q[i]   <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] - CW'(1);
          end
          S_DONE: if (resp_ready[i]) state_q[i] <= S_IDLE;
          default: state_q[i] <= S_IDLE;
        endcase
      end
    end
  end

`ifdef FPU_SHARED_STATS_EN
  logic        any_busy;
  logic [31:0] stat_issued_q, stat_conflict_q, stat_busy_q;

  always_comb begin
    any_busy = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) any_busy = any_busy | (state_q[i] == S_BUSY);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_issued_q   <= '0;
      stat_conflict_q <= '0;
      stat_busy_q     <= '0;
    end else begin
      if (grant_any && stat_issued_q != '1) stat_issued_q <= stat_issued_q + 32'd1;
      if (|(eligible & ~grant_oh) && stat_conflict_q != '1)
        stat_conflict_q <= stat_conflict_q + 32'd1;
      if (any_busy && stat_busy_q != '1) stat_busy_q <= stat_busy_q + 32'd1;
    end
  end

  assign stat_issued   = stat_issued_q;
  assign stat_conflict = stat_conflict_q;
  assign stat_busy     = stat_busy_q;
`endif

endmodule

// File: tb/tb_fpu_shared_rr.sv
// Directed bench for fpu_shared_rr: timing, arbitration, backpressure, reset abort, optional stats.
module tb_fpu_shared_rr;

  localparam int NP = 4;

  logic             clock;
  logic             reset_n;
  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_ready;
  logic [NP*32-1:0] req_a, req_b;
  logic [NP*7-1:0]  req_funct7;
  logic [NP*3-1:0]  req_funct3;
  logic [NP-1:0]    req_rs2b0;
  logic [NP-1:0]    resp_valid;
  logic [NP-1:0]    resp_ready;
  logic [NP*32-1:0] resp_data;
`ifdef FPU_SHARED_STATS_EN
  logic [31:0] stat_issued, stat_conflict, stat_busy;
`endif

  int n_total = 0;
  int n_bad   = 0;

  fpu_shared_rr #(.NUM_PORTS(NP), .MAX_LAT(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_funct7 (req_funct7),
    .req_funct3 (req_funct3),
    .req_rs2b0  (req_rs2b0),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
`ifdef FPU_SHARED_STATS_EN
    ,
    .stat_issued   (stat_issued),
    .stat_conflict (stat_conflict),
    .stat_busy     (stat_busy)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [6:0] f7, input logic [2:0] f3, input logic r2);
    req_a[32*p +: 32]     = a;
    req_b[32*p +: 32]     = b;
    req_funct7[7*p +: 7]  = f7;
    req_funct3[3*p +: 3]  = f3;
    req_rs2b0[p]          = r2;
  endtask

  // Single-port op: checks grant, exact latency from the grant edge, data, and release.
  task automatic run_op(input string tag, input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [6:0] f7, input logic [2:0] f3, input logic r2,
                        input int exp_lat, input logic [31:0] exp_data);
    int n;
    @(posedge clock); #1;
    set_port(p, a, b, f7, f3, r2);
    req_valid[p] = 1'b1;
    #1 check({tag, "_rdy"}, 32'(req_ready), 32'(1) << p);
    @(posedge clock); #1;
    req_valid[p] = 1'b0;
    n = 0;
    while (!resp_valid[p] && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_data"}, resp_data[32*p +: 32], exp_data);
    resp_ready[p] = 1'b1;
    @(posedge clock); #1;
    resp_ready[p] = 1'b0;
    check({tag, "_clr"}, 32'(resp_valid[p]), 32'd0);
  endtask

  task automatic drain(input int cycles);
    resp_ready = '1;
    repeat (cycles) @(posedge clock);
    #1 resp_ready = '0;
  endtask

  logic [NP-1:0] rdy_tab [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  logic [NP-1:0] rv_tab  [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};

  initial begin
    logic [31:0] held;
    int          n_issue;
    logic        seen;
    reset_n    = 1'b0;
    req_valid  = '1;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    req_funct7 = '0;
    req_funct3 = '0;
    req_rs2b0  = '0;

    // Reset state, with requests already pending.
    #3;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_data0", resp_data[31:0], 32'd0);
    check("rst_data3", resp_data[127:96], 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset_n   = 1'b1;
    req_valid = '0;

    // All four contend from rr_ptr=0: grants P0..P3 on consecutive cycles.
    @(posedge clock); #1;
    set_port(0, 32'h3F800000, 32'h40000000, 7'h00, 3'd0, 1'b0);
    set_port(1, 32'h40000000, 32'h40000000, 7'h00, 3'd0, 1'b0);
    set_port(2, 32'h3F800000, 32'h3F800000, 7'h00, 3'd0, 1'b0);
    set_port(3, 32'h3F800000, 32'h00000000, 7'h00, 3'd0, 1'b0);
    req_valid = '1;
    for (int k = 0; k < 7; k++) begin
      #1 check($sformatf("rr_rdy%0d", k), 32'(req_ready), 32'(rdy_tab[k]));
      @(posedge clock); #1;
      if (k < 4) req_valid[k] = 1'b0;
      check($sformatf("rr_rv%0d", k), 32'(resp_valid), 32'(rv_tab[k]));
    end
    check("rr_d0", resp_data[31:0],   32'h40400000);
    check("rr_d1", resp_data[63:32],  32'h40800000);
    check("rr_d2", resp_data[95:64],  32'h40000000);
    check("rr_d3", resp_data[127:96], 32'h3F800000);
    drain(1);
    check("rr_drained", 32'(resp_valid), 32'd0);
`ifdef FPU_SHARED_STATS_EN
    check("stat_issued", stat_issued, 32'd4);
    check("stat_conflict", stat_conflict, 32'd3);
    check("stat_busy", stat_busy, 32'd6);
`endif

    // rr_ptr wrapped back to 0: P0 wins over P3.
    @(posedge clock); #1;
    set_port(0, 32'h3F800000, 32'h0, 7'h10, 3'd0, 1'b0);
    set_port(3, 32'h3F800000, 32'h0, 7'h10, 3'd0, 1'b0);
    req_valid = 4'b1001;
    #1 check("ptr0_first", 32'(req_ready), 32'b0001);
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    #1 check("ptr0_second", 32'(req_ready), 32'b1000);
    @(posedge clock); #1;
    req_valid[3] = 1'b0;
    drain(4);
    check("ptr0_drained", 32'(resp_valid), 32'd0);

    // Single-port ops: function results and clamped latencies.
    run_op("fadd",   0, 32'h3F800000, 32'h40000000, 7'h00, 3'd0, 1'b0, 3,  32'h40400000);
    run_op("fsub",   1, 32'h40400000, 32'h3F800000, 7'h04, 3'd0, 1'b0, 3,  32'h40000000);
    run_op("fsubn",  2, 32'h3F800000, 32'h40400000, 7'h04, 3'd0, 1'b0, 3,  32'hC0000000);
    run_op("fmul",   2, 32'h40000000, 32'h40400000, 7'h08, 3'd0, 1'b0, 5,  32'h40C00000);
    run_op("fsgnjn", 1, 32'h3F800000, 32'h00000000, 7'h10, 3'd1, 1'b0, 1,  32'hBF800000);
    run_op("cvt5",   3, 32'd5,        32'h0,        7'h68, 3'd0, 1'b0, 32, 32'h40A00000);
    run_op("cvtm1",  0, 32'hFFFFFFFF, 32'h0,        7'h68, 3'd0, 1'b0, 32, 32'hBF800000);
    run_op("cvtu",   0, 32'hFFFFFFFF, 32'h0,        7'h68, 3'd0, 1'b1, 32, 32'h4F7FFFFF);

    // Backpressure on P1 while P0 and P2 keep issuing.
    @(posedge clock); #1;
    set_port(1, 32'h40400000, 32'h80000000, 7'h10, 3'd0, 1'b0);
    req_valid[1] = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    held = 32'hC0400000;
    check("bp_done", 32'(resp_valid[1]), 32'd1);
    set_port(0, 32'h3F800000, 32'h0, 7'h10, 3'd0, 1'b0);
    set_port(2, 32'h3F800000, 32'h0, 7'h10, 3'd0, 1'b0);
    req_valid  = 4'b0111;
    resp_ready = 4'b0101;
    n_issue = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("bp_rdy1_%0d", k), 32'(req_ready[1]), 32'd0);
      n_issue += int'(req_ready[0]) + int'(req_ready[2]);
      @(posedge clock); #1;
      check($sformatf("bp_rv1_%0d", k), 32'(resp_valid[1]), 32'd1);
      check($sformatf("bp_d1_%0d", k), resp_data[63:32], held);
    end
    check("bp_others_issued", n_issue, 7);
    req_valid = '0;
    drain(8);
    check("bp_drained", 32'(resp_valid), 32'd0);

    // Reset two cycles into a 5-cycle op: immediate clear, no late response.
    @(posedge clock); #1;
    set_port(0, 32'h40000000, 32'h40400000, 7'h08, 3'd0, 1'b0);
    req_valid[0] = 1'b1;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_data0", resp_data[31:0], 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clock); #1;
      seen = seen | resp_valid[0];
    end
    check("mid_rst_no_resp", 32'(seen), 32'd0);
    check("mid_rst_data_after", resp_data[31:0], 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
